// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and entry type for the fetch/decode queue
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order {pc, instr, pc+4} buffer between fetch and decode with flush
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_pc,
  input  logic [W-1:0]             in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_pc,
  output logic [W-1:0]             out_instr,
  output logic [W-1:0]             out_pc4,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  fetch_entry_t head;
  logic push, pop;
  assign in_ready = count_q != CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign count = count_q;
  // next-state: flush wins over push/pop; pointers wrap naturally at DEPTH
  always_comb begin
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    mem_d = mem_q;
    if (push && !flush)
      mem_d[wr_ptr_q] = '{pc: XLEN'(in_pc), instr: XLEN'(in_instr), pc4: XLEN'(in_pc + W'(PC_INC))};
  end
  // head presentation: empty queue shows pc 0 and a NOP
  always_comb begin
    head = mem_q[rd_ptr_q];
    out_pc = out_valid ? W'(head.pc) : '0;
    out_pc4 = out_valid ? W'(head.pc4) : '0;
    out_instr = out_valid ? W'(head.instr) : W'(NOP_INSTR);
  end
  // pointer and occupancy state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  // entry storage needs no reset; only slots below count are ever shown
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table vectors, corner sequences and random traffic against a queue model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0, rst = 0;
  logic in_valid = 0, out_ready = 0, flush = 0;
  logic [31:0] in_pc = 0, in_instr = 0;
  logic in_ready, out_valid;
  logic [31:0] out_pc, out_instr, out_pc4;
  logic [2:0] count;
  int errors = 0, checks = 0;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t mq[$];

  typedef struct {
    logic iv; logic [31:0] pc; logic [31:0] instr; logic ordy; logic fl;
    logic ev; int ec; logic [31:0] epc; logic [31:0] epc4; logic [31:0] einstr; logic erdy;
  } vec_t;
  vec_t tbl [12];

  fetch_queue #(.W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_pc4(out_pc4), .out_ready(out_ready), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic check_model();
    logic ev;
    logic [31:0] epc, ein;
    ev = mq.size() != 0;
    epc = ev ? mq[0].pc : 32'h0;
    ein = ev ? mq[0].instr : NOP;
    chk("model out_valid", 32'(out_valid), 32'(ev));
    chk("model in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    chk("model count", 32'(count), mq.size());
    chk("model out_pc", out_pc, epc);
    chk("model out_pc4", out_pc4, ev ? epc + 32'd4 : 32'h0);
    chk("model out_instr", out_instr, ein);
  endtask

  task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                      input logic ordy, input logic fl);
    int sz;
    bit pp, pu;
    sz = mq.size();
    in_valid = iv; in_pc = pc; in_instr = instr; out_ready = ordy; flush = fl;
    pp = sz > 0 && ordy;
    pu = iv && sz < DEPTH;
    if (fl) mq.delete();
    else begin
      if (pp) void'(mq.pop_front());
      if (pu) mq.push_back('{pc, instr});
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    tbl = '{
      '{1, 32'h00, 32'hA0, 0, 0,  1, 1, 32'h00, 32'h04, 32'hA0, 1},
      '{1, 32'h04, 32'hA1, 0, 0,  1, 2, 32'h00, 32'h04, 32'hA0, 1},
      '{1, 32'h08, 32'hA2, 0, 0,  1, 3, 32'h00, 32'h04, 32'hA0, 1},
      '{1, 32'h0C, 32'hA3, 0, 0,  1, 4, 32'h00, 32'h04, 32'hA0, 0},
      '{1, 32'h10, 32'hFF, 0, 0,  1, 4, 32'h00, 32'h04, 32'hA0, 0},
      '{0, 32'h00, 32'h00, 1, 0,  1, 3, 32'h04, 32'h08, 32'hA1, 1},
      '{0, 32'h00, 32'h00, 1, 0,  1, 2, 32'h08, 32'h0C, 32'hA2, 1},
      '{0, 32'h00, 32'h00, 1, 0,  1, 1, 32'h0C, 32'h10, 32'hA3, 1},
      '{0, 32'h00, 32'h00, 1, 0,  0, 0, 32'h00, 32'h00, NOP,    1},
      '{1, 32'h20, 32'hB0, 1, 0,  1, 1, 32'h20, 32'h24, 32'hB0, 1},
      '{1, 32'h40, 32'hC0, 1, 1,  0, 0, 32'h00, 32'h00, NOP,    1},
      '{0, 32'h00, 32'h00, 0, 1,  0, 0, 32'h00, 32'h00, NOP,    1}
    };
    #12;
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset in_ready", 32'(in_ready), 32'h1);
    chk("reset out_instr", out_instr, NOP);
    chk("reset out_pc", out_pc, 32'h0);
    rst = 1;
    step(0, 0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].iv, tbl[i].pc, tbl[i].instr, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d count", i), 32'(count), tbl[i].ec);
      chk($sformatf("vec%0d out_pc", i), out_pc, tbl[i].epc);
      chk($sformatf("vec%0d out_pc4", i), out_pc4, tbl[i].epc4);
      chk($sformatf("vec%0d out_instr", i), out_instr, tbl[i].einstr);
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].erdy));
    end

    for (int i = 0; i < 3; i++) step(1, 32'h30 + 32'(4 * i), 32'hD0 + 32'(i), 0, 0);
    step(1, 32'h40, 32'hC0, 1, 1);
    chk("flush out_valid", 32'(out_valid), 32'h0);
    chk("flush count", 32'(count), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(i == 0, 32'h50, 32'hE0, 1, 0);
      chk("post flush pc", out_pc, i == 0 ? 32'h50 : 32'h0);
    end

    for (int i = 0; i < 10; i++) begin
      step(1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1, 0);
      chk("stream out_pc", out_pc, 32'h100 + 32'(4 * i));
      chk("stream count", 32'(count), 32'h1);
    end
    step(0, 0, 0, 1, 0);

    step(1, 32'hFFFFFFFC, 32'h55, 0, 0);
    chk("wrap out_pc4", out_pc4, 32'h0);
    step(0, 0, 0, 1, 0);

    step(1, 32'h200, 32'h77, 0, 0);
    step(1, 32'h204, 32'h78, 0, 0);
    #3 rst = 0;
    #1;
    mq.delete();
    chk("async out_valid", 32'(out_valid), 32'h0);
    chk("async count", 32'(count), 32'h0);
    chk("async out_instr", out_instr, NOP);
    chk("async out_pc4", out_pc4, 32'h0);
    check_model();
    #1 rst = 1;
    step(0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++)
      step($urandom % 4 != 0, $urandom & 32'hFFFFFFFC, $urandom, $urandom % 2 == 1, $urandom % 16 == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
